// File: rtl/terminal_qsys_pkg.sv
// Shared types for the Qsys state-PIO poller: FSM encoding, PIO width, event payload.
package terminal_qsys_pkg;

  localparam int unsigned PIO_DW = 32;
  localparam int unsigned EVT_W  = 2 * PIO_DW;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_CAPTURE = 2'd2
  } poll_state_e;

  typedef struct packed {
    logic [PIO_DW-1:0] data;
    logic [PIO_DW-1:0] diff;
  } evt_t;

endpackage

// File: rtl/terminal_qsys_state_evfifo.sv
// First-word-fall-through event FIFO; head is visible whenever valid_o is high.
module terminal_qsys_state_evfifo
  import terminal_qsys_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push_i,
  input  evt_t push_data_i,
  input  logic pop_i,
  output logic valid_o,
  output logic full_o,
  output evt_t head_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  evt_t          mem_q [DEPTH];
  evt_t          mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/terminal_qsys_state_poller.sv
// Periodically reads a state PIO over Avalon-MM and queues masked change events.
module terminal_qsys_state_poller
  import terminal_qsys_pkg::*;
#(
  parameter int unsigned       POLL_DIV   = 1000,
  parameter logic [PIO_DW-1:0] CHG_MASK   = 32'hFFFF_FFFF,
  parameter int unsigned       FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [1:0]        avm_address,
  output logic              avm_read,
  input  logic [PIO_DW-1:0] avm_readdata,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [PIO_DW-1:0] evt_data,
  output logic [PIO_DW-1:0] evt_diff,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int unsigned CNT_W = 16;

  poll_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              avm_read_q, avm_read_d;
  logic [PIO_DW-1:0] last_q, last_d;
  logic              base_q, base_d;
  logic              ovf_q, ovf_d;

  logic              tick_c;
  logic              push_c;
  logic              pop_c;
  logic              fifo_full_c;
  logic [PIO_DW-1:0] masked_c;
  logic [PIO_DW-1:0] diff_c;
  evt_t              push_evt_c;
  evt_t              head_c;

  assign pop_c = evt_valid && evt_ready;

  // Poll timer, read FSM and change detection.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    avm_read_d = 1'b0;
    last_d     = last_q;
    base_d     = base_q;
    push_c     = 1'b0;
    ovf_d      = ovf_q;

    tick_c = enable && (cnt_q == '0);
    if (!enable) begin
      cnt_d = '0;
    end else if (tick_c) begin
      cnt_d = CNT_W'(POLL_DIV - 1);
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    masked_c   = avm_readdata & CHG_MASK;
    diff_c     = masked_c ^ last_q;
    push_evt_c = '{data: masked_c, diff: diff_c};

    case (state_q)
      ST_IDLE: begin
        if (tick_c) begin
          state_d    = ST_READ;
          avm_read_d = 1'b1;
        end
      end
      ST_READ: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = ST_IDLE;
        if (!base_q) begin
          base_d = 1'b1;
          last_d = masked_c;
        end else if (diff_c != '0) begin
          // last tracks the bus even when the event is dropped.
          last_d = masked_c;
          push_c = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (push_c && fifo_full_c && !pop_c) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      avm_read_q <= 1'b0;
      last_q     <= '0;
      base_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      avm_read_q <= avm_read_d;
      last_q     <= last_d;
      base_q     <= base_d;
      ovf_q      <= ovf_d;
    end
  end

  terminal_qsys_state_evfifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_evfifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push_c),
    .push_data_i (push_evt_c),
    .pop_i       (pop_c),
    .valid_o     (evt_valid),
    .full_o      (fifo_full_c),
    .head_o      (head_c)
  );

  assign avm_address = 2'b00;
  assign avm_read    = avm_read_q;
  assign evt_data    = head_c.data;
  assign evt_diff    = head_c.diff;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_terminal_qsys_state_poller.sv
// Scoreboard bench: a PIO responder plus a reference model of the event FIFO.
module tb_terminal_qsys_state_poller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        enable0 = 1'b0, enable1 = 1'b0;
  logic [1:0]  addr0, addr1;
  logic        rd0, rd1;
  logic [31:0] rdata0 = 32'h0, rdata1 = 32'h0;
  logic [31:0] pio0 = 32'h0, pio1 = 32'h0;
  logic        evt_valid0, evt_valid1;
  logic        evt_ready0 = 1'b0, evt_ready1 = 1'b0;
  logic [31:0] evt_data0, evt_data1, evt_diff0, evt_diff1;
  logic        ovf0, ovf1;
  logic        ovf_clr0 = 1'b0, ovf_clr1 = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [63:0] mq[$];
  logic        cap_pend = 1'b0;
  logic [31:0] cap_val  = 32'h0;
  logic        base_m   = 1'b0;
  logic [31:0] last_m   = 32'h0;
  logic        exp_ovf  = 1'b0;

  always #5 clk = ~clk;

  terminal_qsys_state_poller #(.POLL_DIV(4), .CHG_MASK(32'hFFFF_FFFF), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .enable(enable0), .avm_address(addr0), .avm_read(rd0),
    .avm_readdata(rdata0), .evt_valid(evt_valid0), .evt_ready(evt_ready0),
    .evt_data(evt_data0), .evt_diff(evt_diff0), .overflow(ovf0), .ovf_clr(ovf_clr0));

  terminal_qsys_state_poller #(.POLL_DIV(4), .CHG_MASK(32'h0000_00FF), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .enable(enable1), .avm_address(addr1), .avm_read(rd1),
    .avm_readdata(rdata1), .evt_valid(evt_valid1), .evt_ready(evt_ready1),
    .evt_data(evt_data1), .evt_diff(evt_diff1), .overflow(ovf1), .ovf_clr(ovf_clr1));

  // PIO slaves with fixed read latency of one cycle.
  always @(posedge clk) begin
    rdata0 <= rd0 ? pio0 : 32'hDEAD_BEEF;
    rdata1 <= rd1 ? pio1 : 32'hDEAD_BEEF;
  end

  // Reference model of dut0: expected FIFO contents and overflow flag.
  initial begin : model
    logic [31:0] m, d;
    bit pop, push, set;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        mq.delete(); cap_pend = 1'b0; base_m = 1'b0; last_m = 32'h0; exp_ovf = 1'b0;
      end else begin
        pop = evt_ready0 && (mq.size() > 0);
        push = 1'b0; set = 1'b0;
        if (cap_pend) begin
          m = cap_val; d = m ^ last_m;
          if (!base_m) begin
            base_m = 1'b1; last_m = m;
          end else if (d != 0) begin
            last_m = m;
            if (mq.size() < 4 || pop) push = 1'b1; else set = 1'b1;
          end
        end
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back({m, d});
        if (set) exp_ovf = 1'b1; else if (ovf_clr0) exp_ovf = 1'b0;
        cap_pend = rd0;
        cap_val  = pio0;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0; enable0 = 1'b0; enable1 = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic poll(input bit sel, input logic [31:0] v, input bit pop_at_cap);
    int n;
    @(negedge clk);
    if (sel) begin pio1 = v; enable1 = 1'b1; end
    else     begin pio0 = v; enable0 = 1'b1; end
    n = 0;
    do begin @(negedge clk); n++; end while (!(sel ? rd1 : rd0) && n < 40);
    enable0 = 1'b0; enable1 = 1'b0;
    total++;
    if ((sel ? rd1 : rd0) !== 1'b1) begin bad++; $display("FAIL poll_timeout: read strobe got 0 want 1"); end
    if (pop_at_cap) begin
      @(negedge clk); evt_ready0 = 1'b1;
      @(negedge clk); evt_ready0 = 1'b0;
      @(negedge clk);
    end else begin
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic drain0();
    @(negedge clk); evt_ready0 = 1'b1;
    @(negedge clk); evt_ready0 = 1'b0;
  endtask

  // Head of dut0 against the scoreboard and against the expected constant pair.
  task automatic test_head0(input string tag, input logic [31:0] ed, input logic [31:0] ef);
    logic [63:0] exp;
    exp = (mq.size() != 0) ? mq[0] : 64'h0;
    total++;
    if (evt_valid0 !== 1'b1 || {evt_data0, evt_diff0} !== exp) begin
      bad++; $display("FAIL %s_sb: got v=%b %h/%h want v=1 %h", tag, evt_valid0, evt_data0, evt_diff0, exp);
    end
    total++;
    if (evt_data0 !== ed || evt_diff0 !== ef) begin
      bad++; $display("FAIL %s_val: got %h/%h want %h/%h", tag, evt_data0, evt_diff0, ed, ef);
    end
    drain0();
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({rd0, addr0, evt_valid0, evt_data0, evt_diff0, ovf0} !== 70'h0) begin
      bad++; $display("FAIL reset_dut0: got rd=%b a=%h v=%b d=%h x=%h o=%b want all 0", rd0, addr0, evt_valid0, evt_data0, evt_diff0, ovf0);
    end
    total++;
    if ({rd1, addr1, evt_valid1, evt_data1, evt_diff1, ovf1} !== 70'h0) begin
      bad++; $display("FAIL reset_dut1: got rd=%b v=%b d=%h o=%b want all 0", rd1, evt_valid1, evt_data1, ovf1);
    end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_poll_timing();
    @(negedge clk); pio0 = 32'h0; enable0 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      total++;
      if (rd0 !== (k % 4 == 0) || addr0 !== 2'b00) begin
        bad++; $display("FAIL read_cycle%0d: got rd=%b addr=%h want rd=%b addr=0", k, rd0, addr0, (k % 4 == 0));
      end
    end
    enable0 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++;
      if (rd0 !== 1'b0) begin bad++; $display("FAIL read_disabled%0d: got %b want 0", k, rd0); end
    end
    total++;
    if (evt_valid0 !== 1'b0) begin bad++; $display("FAIL timing_no_evt: got %b want 0", evt_valid0); end
  endtask

  task automatic test_change();
    do_reset();
    poll(1'b0, 32'h5, 1'b0);
    total++;
    if (evt_valid0 !== 1'b0) begin bad++; $display("FAIL baseline_evt: got %b want 0", evt_valid0); end
    poll(1'b0, 32'h7, 1'b0);
    poll(1'b0, 32'h7, 1'b0);
    test_head0("chg", 32'h7, 32'h2);
    @(negedge clk);
    total++;
    if (evt_valid0 !== 1'b0) begin bad++; $display("FAIL chg_single: got valid %b want 0", evt_valid0); end
  endtask

  task automatic test_mask();
    do_reset();
    poll(1'b1, 32'h100, 1'b0);
    poll(1'b1, 32'h1FF, 1'b0);
    total++;
    if (evt_valid1 !== 1'b1 || evt_data1 !== 32'hFF || evt_diff1 !== 32'hFF) begin
      bad++; $display("FAIL mask_evt: got v=%b %h/%h want v=1 000000ff/000000ff", evt_valid1, evt_data1, evt_diff1);
    end
    @(negedge clk); evt_ready1 = 1'b1;
    @(negedge clk); evt_ready1 = 1'b0;
    poll(1'b1, 32'h0FF, 1'b0);
    total++;
    if (evt_valid1 !== 1'b0) begin bad++; $display("FAIL mask_hidden: got valid %b want 0", evt_valid1); end
  endtask

  task automatic test_overflow();
    do_reset();
    poll(1'b0, 32'h0, 1'b0);
    for (int i = 1; i <= 5; i++) poll(1'b0, 32'(i), 1'b0);
    total++;
    if (ovf0 !== 1'b1 || ovf0 !== exp_ovf) begin bad++; $display("FAIL ovf_set: got %b want 1", ovf0); end
    test_head0("ovf0", 32'h1, 32'h1);
    test_head0("ovf1", 32'h2, 32'h3);
    test_head0("ovf2", 32'h3, 32'h1);
    test_head0("ovf3", 32'h4, 32'h7);
    @(negedge clk);
    total++;
    if (evt_valid0 !== 1'b0 || ovf0 !== 1'b1) begin
      bad++; $display("FAIL ovf_sticky: got v=%b ovf=%b want v=0 ovf=1", evt_valid0, ovf0);
    end
    poll(1'b0, 32'h5, 1'b0);
    total++;
    if (evt_valid0 !== 1'b0) begin bad++; $display("FAIL ovf_last_updated: got valid %b want 0", evt_valid0); end
    @(negedge clk); ovf_clr0 = 1'b1;
    @(negedge clk); ovf_clr0 = 1'b0;
    total++;
    if (ovf0 !== 1'b0 || ovf0 !== exp_ovf) begin bad++; $display("FAIL ovf_clr: got %b want 0", ovf0); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    poll(1'b0, 32'h0, 1'b0);
    for (int i = 1; i <= 4; i++) poll(1'b0, 32'(i), 1'b0);
    poll(1'b0, 32'h5, 1'b1);
    total++;
    if (ovf0 !== 1'b0) begin bad++; $display("FAIL b2b_ovf: got %b want 0", ovf0); end
    test_head0("b2b0", 32'h2, 32'h3);
    test_head0("b2b1", 32'h3, 32'h1);
    test_head0("b2b2", 32'h4, 32'h7);
    test_head0("b2b3", 32'h5, 32'h1);
  endtask

  task automatic test_reset_mid_read();
    int n;
    do_reset();
    poll(1'b0, 32'h11, 1'b0);
    @(negedge clk); pio0 = 32'h55; enable0 = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (rd0 !== 1'b1 && n < 40);
    reset_n = 1'b0; enable0 = 1'b0;
    #1;
    total++;
    if (rd0 !== 1'b0) begin bad++; $display("FAIL rst_async_read: got %b want 0", rd0); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (evt_valid0 !== 1'b0) begin bad++; $display("FAIL rst_inflight_evt: got %b want 0", evt_valid0); end
    poll(1'b0, 32'h66, 1'b0);
    total++;
    if (evt_valid0 !== 1'b0) begin bad++; $display("FAIL rst_rebaseline: got %b want 0", evt_valid0); end
    poll(1'b0, 32'h67, 1'b0);
    test_head0("rst_after", 32'h67, 32'h1);
  endtask

  initial begin
    test_reset();
    test_poll_timing();
    test_change();
    test_mask();
    test_overflow();
    test_back_to_back();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
